// File: rtl/reversi_pkg.sv
// Shared constants and types for the reversi board renderer: piece codes,
// palette, board geometry defaults and the cell-sweep state encoding.
package reversi_pkg;

   localparam int unsigned DEF_CELL     = 14;
   localparam int unsigned DEF_ORIGIN_X = 24;
   localparam int unsigned DEF_ORIGIN_Y = 4;

   localparam logic [2:0] C_BOARD  = 3'b010;
   localparam logic [2:0] C_GRID   = 3'b000;
   localparam logic [2:0] C_BLACK  = 3'b000;
   localparam logic [2:0] C_WHITE  = 3'b111;
   localparam logic [2:0] C_HILITE = 3'b110;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      BLACK  = 2'd1,
      WHITE  = 2'd2,
      HILITE = 2'd3
   } piece_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/node_pixel_colour.sv
// Colour of one pixel inside a board cell, from its cell-local offset and the
// piece occupying the cell. Purely combinational.
module node_pixel_colour
   import reversi_pkg::*;
#(
   parameter int unsigned CELL          = DEF_CELL,
   parameter logic [2:0]  BOARD_COLOUR  = C_BOARD,
   parameter logic [2:0]  GRID_COLOUR   = C_GRID,
   parameter logic [2:0]  BLACK_COLOUR  = C_BLACK,
   parameter logic [2:0]  WHITE_COLOUR  = C_WHITE,
   parameter logic [2:0]  HILITE_COLOUR = C_HILITE
) (
   input  logic [$clog2(CELL)-1:0] i_dx,
   input  logic [$clog2(CELL)-1:0] i_dy,
   input  piece_e                  i_piece,
   output logic [2:0]              o_colour
);

   localparam int unsigned CW = $clog2(CELL);
   localparam logic [CW-1:0] INSET_LO = CW'(3);
   localparam logic [CW-1:0] INSET_HI = CW'(CELL - 4);
   localparam logic [CW-1:0] MID_A    = CW'(CELL / 2 - 1);
   localparam logic [CW-1:0] MID_B    = CW'(CELL / 2);

   logic w_border;
   logic w_in_inset;
   logic w_inset_corner;
   logic w_in_dot;

   // Only the top and left edges are drawn; the neighbour cell supplies the rest.
   assign w_border       = (i_dx == '0) || (i_dy == '0);
   assign w_in_inset     = (i_dx >= INSET_LO) && (i_dx <= INSET_HI) &&
                           (i_dy >= INSET_LO) && (i_dy <= INSET_HI);
   assign w_inset_corner = ((i_dx == INSET_LO) || (i_dx == INSET_HI)) &&
                           ((i_dy == INSET_LO) || (i_dy == INSET_HI));
   assign w_in_dot       = ((i_dx == MID_A) || (i_dx == MID_B)) &&
                           ((i_dy == MID_A) || (i_dy == MID_B));

   always_comb begin
      o_colour = BOARD_COLOUR;
      if (w_border) begin
         o_colour = GRID_COLOUR;
      end else if ((i_piece == BLACK) && w_in_inset && !w_inset_corner) begin
         o_colour = BLACK_COLOUR;
      end else if ((i_piece == WHITE) && w_in_inset && !w_inset_corner) begin
         o_colour = WHITE_COLOUR;
      end else if ((i_piece == HILITE) && w_in_dot) begin
         o_colour = HILITE_COLOUR;
      end
   end

endmodule

// File: rtl/node_plotter.sv
// Sweeps one reversi board cell row-major and emits one registered
// colour/x/y/plot write per cycle for the VGA adapter's write port.
module node_plotter
   import reversi_pkg::*;
#(
   parameter int unsigned CELL          = DEF_CELL,
   parameter int unsigned ORIGIN_X      = DEF_ORIGIN_X,
   parameter int unsigned ORIGIN_Y      = DEF_ORIGIN_Y,
   parameter logic [2:0]  BOARD_COLOUR  = C_BOARD,
   parameter logic [2:0]  GRID_COLOUR   = C_GRID,
   parameter logic [2:0]  BLACK_COLOUR  = C_BLACK,
   parameter logic [2:0]  WHITE_COLOUR  = C_WHITE,
   parameter logic [2:0]  HILITE_COLOUR = C_HILITE
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] cell_row,
   input  logic [2:0] cell_col,
   input  logic [1:0] piece,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   localparam int unsigned   CW   = $clog2(CELL);
   localparam logic [CW-1:0] LAST = CW'(CELL - 1);

   state_e        r_state, w_state_nxt;
   logic [CW-1:0] r_dx, r_dy, w_dx_nxt, w_dy_nxt;
   logic [2:0]    r_row, r_col, w_row_nxt, w_col_nxt;
   piece_e        r_piece, w_piece_nxt;
   logic [7:0]    r_x, w_x_nxt;
   logic [6:0]    r_y, w_y_nxt;
   logic [2:0]    r_colour, w_colour_nxt;
   logic          r_plot, w_plot_nxt;
   logic          r_done, w_done_nxt;

   logic [7:0]    w_base_x;
   logic [6:0]    w_base_y;
   logic [2:0]    w_pix_colour;

   assign w_base_x = 8'(ORIGIN_X) + 8'(r_col) * 8'(CELL);
   assign w_base_y = 7'(ORIGIN_Y) + 7'(r_row) * 7'(CELL);

   node_pixel_colour #(
      .CELL          (CELL),
      .BOARD_COLOUR  (BOARD_COLOUR),
      .GRID_COLOUR   (GRID_COLOUR),
      .BLACK_COLOUR  (BLACK_COLOUR),
      .WHITE_COLOUR  (WHITE_COLOUR),
      .HILITE_COLOUR (HILITE_COLOUR)
   ) u_pixel_colour (
      .i_dx     (r_dx),
      .i_dy     (r_dy),
      .i_piece  (r_piece),
      .o_colour (w_pix_colour)
   );

   // DONE is the cycle the last pixel sits on the bus; done is raised as we
   // return to IDLE, so the done cycle is already able to accept a new start.
   always_comb begin
      w_state_nxt  = r_state;
      w_dx_nxt     = r_dx;
      w_dy_nxt     = r_dy;
      w_row_nxt    = r_row;
      w_col_nxt    = r_col;
      w_piece_nxt  = r_piece;
      w_x_nxt      = '0;
      w_y_nxt      = '0;
      w_colour_nxt = '0;
      w_plot_nxt   = 1'b0;
      w_done_nxt   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_row_nxt   = cell_row;
               w_col_nxt   = cell_col;
               w_piece_nxt = piece_e'(piece);
               w_dx_nxt    = '0;
               w_dy_nxt    = '0;
               w_state_nxt = SWEEP;
            end
         end
         SWEEP: begin
            w_plot_nxt   = 1'b1;
            w_x_nxt      = w_base_x + 8'(r_dx);
            w_y_nxt      = w_base_y + 7'(r_dy);
            w_colour_nxt = w_pix_colour;
            if (r_dx == LAST) begin
               w_dx_nxt = '0;
               if (r_dy == LAST) begin
                  w_state_nxt = DONE;
               end else begin
                  w_dy_nxt = r_dy + 1'b1;
               end
            end else begin
               w_dx_nxt = r_dx + 1'b1;
            end
         end
         DONE: begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state  <= IDLE;
         r_dx     <= '0;
         r_dy     <= '0;
         r_row    <= '0;
         r_col    <= '0;
         r_piece  <= EMPTY;
         r_x      <= '0;
         r_y      <= '0;
         r_colour <= '0;
         r_plot   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_dx     <= w_dx_nxt;
         r_dy     <= w_dy_nxt;
         r_row    <= w_row_nxt;
         r_col    <= w_col_nxt;
         r_piece  <= w_piece_nxt;
         r_x      <= w_x_nxt;
         r_y      <= w_y_nxt;
         r_colour <= w_colour_nxt;
         r_plot   <= w_plot_nxt;
         r_done   <= w_done_nxt;
      end
   end

   assign x      = r_x;
   assign y      = r_y;
   assign colour = r_colour;
   assign plot   = r_plot;
   assign done   = r_done;
   assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_node_plotter.sv
// Bench for node_plotter: timestamped pixel/done expectations from a geometric
// model, consumed by an independent output monitor; plus directed spot checks.
module tb_node_plotter;

  localparam int CELL = 14;
  localparam int OX   = 24;
  localparam int OY   = 4;
  localparam int NPIX = CELL * CELL;
  localparam int W    = 39;  // {is_done, stamp[19:0], x[7:0], y[6:0], colour[2:0]}

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] cell_row;
  logic [2:0] cell_col;
  logic [1:0] piece;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int plot_cnt = 0;
  int done_cnt = 0;
  int first_x, first_y, last_x, last_y;
  logic [2:0] obs[0:159][0:119];

  node_plotter dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .start    (start),
    .cell_row (cell_row),
    .cell_col (cell_col),
    .piece    (piece),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // reference model: the cell drawn from its geometric description
  function automatic logic [2:0] ref_colour(input int dx, input int dy, input int pc);
    int  lo = 3;
    int  hi = CELL - 4;
    bit  in_disc;
    bit  in_dot;
    if (dx == 0 || dy == 0) return 3'b000;
    in_disc = (dx >= lo && dx <= hi && dy >= lo && dy <= hi) &&
              !((dx == lo || dx == hi) && (dy == lo || dy == hi));
    in_dot  = (dx == CELL/2 - 1 || dx == CELL/2) && (dy == CELL/2 - 1 || dy == CELL/2);
    if (pc == 1 && in_disc) return 3'b000;
    if (pc == 2 && in_disc) return 3'b111;
    if (pc == 3 && in_dot)  return 3'b110;
    return 3'b010;
  endfunction

  function automatic logic [W-1:0] pack(input bit d, input int stamp, input int px,
                                        input int py, input logic [2:0] c);
    return {d, 20'(stamp), 8'(px), 7'(py), c};
  endfunction

  // driver: call at a negedge; start is sampled at the next posedge (edge k)
  task automatic issue(input int row, input int col, input int pc);
    int k;
    check("accept_busy_low", 32'(busy), 32'd0);
    start    = 1'b1;
    cell_row = 3'(row);
    cell_col = 3'(col);
    piece    = 2'(pc);
    k = cyc + 1;
    for (int dy = 0; dy < CELL; dy++)
      for (int dx = 0; dx < CELL; dx++)
        exp_q.push_back(pack(1'b0, k + 1 + dy * CELL + dx, OX + col * CELL + dx,
                             OY + row * CELL + dy, ref_colour(dx, dy, pc)));
    exp_q.push_back(pack(1'b1, k + NPIX + 1, 0, 0, 3'b000));
    @(negedge clk);
    start    = 1'b0;
    cell_row = 3'($urandom_range(0, 7));
    cell_col = 3'($urandom_range(0, 7));
    piece    = 2'($urandom_range(0, 3));
  endtask

  // returns at the negedge of the done cycle
  task automatic wait_done(input int target);
    int budget = 400;
    while (done_cnt < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (done_cnt < target) check("done_timeout", 32'(done_cnt), 32'(target));
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (plot || done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: plot=%0b done=%0b x=%0d y=%0d, expected none (cycle %0d)",
                 plot, done, x, y, cyc);
      end else begin
        e = exp_q.pop_front();
        check("out_kind_done", 32'(done), 32'(e[38]));
        check("out_stamp", 32'(cyc), 32'(e[37:18]));
        if (e[38]) begin
          check("done_plot_low", 32'(plot), 32'd0);
          check("done_busy_low", 32'(busy), 32'd0);
        end else begin
          check("pix_x", 32'(x), 32'(e[17:10]));
          check("pix_y", 32'(y), 32'(e[9:3]));
          check("pix_colour", 32'(colour), 32'(e[2:0]));
          check("pix_busy_high", 32'(busy), 32'd1);
        end
      end
      if (plot) begin
        if (plot_cnt == 0) begin
          first_x = int'(x);
          first_y = int'(y);
        end
        last_x = int'(x);
        last_y = int'(y);
        if (x < 8'd160 && y < 7'd120) obs[x][y] = colour;
        plot_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    cell_row = 3'd0;
    cell_col = 3'd0;
    piece    = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_colour", 32'(colour), 32'd0);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // empty cell at the board's top-left corner
    plot_cnt = 0;
    issue(0, 0, 0);
    wait_done(1);
    check("t1_plot_count", 32'(plot_cnt), 32'd196);
    check("t1_first_x", 32'(first_x), 32'd24);
    check("t1_first_y", 32'(first_y), 32'd4);
    check("t1_px_24_4", 32'(obs[24][4]), 32'd0);
    check("t1_px_25_4", 32'(obs[25][4]), 32'd0);
    check("t1_px_25_5", 32'(obs[25][5]), 32'b010);
    check("t1_last_x", 32'(last_x), 32'd37);
    check("t1_last_y", 32'(last_y), 32'd17);
    check("t1_last_colour", 32'(obs[37][17]), 32'b010);
    repeat (2) @(negedge clk);

    // white disc at the bottom-right corner
    plot_cnt = 0;
    issue(7, 7, 2);
    wait_done(2);
    check("t2_disc_centre", 32'(obs[129][109]), 32'b111);
    check("t2_inset_corner", 32'(obs[125][105]), 32'b010);
    check("t2_inset_edge", 32'(obs[125][106]), 32'b111);
    check("t2_last_x", 32'(last_x), 32'd135);
    check("t2_last_y", 32'(last_y), 32'd115);
    @(negedge clk);

    // highlight dot
    plot_cnt = 0;
    issue(3, 4, 3);
    wait_done(3);
    check("t3_base_x", 32'(first_x), 32'd80);
    check("t3_base_y", 32'(first_y), 32'd46);
    for (int px = 86; px <= 87; px++)
      for (int py = 52; py <= 53; py++)
        check("t3_dot", 32'(obs[px][py]), 32'b110);
    check("t3_beside_dot", 32'(obs[85][52]), 32'b010);
    @(negedge clk);

    // start while busy is ignored
    plot_cnt = 0;
    issue(1, 2, 1);
    repeat (49) @(negedge clk);
    start    = 1'b1;
    cell_row = 3'd5;
    cell_col = 3'd6;
    piece    = 2'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(4);
    repeat (4) @(negedge clk);
    check("t4_plot_count", 32'(plot_cnt), 32'd196);
    check("t4_done_count", 32'(done_cnt), 32'd4);

    // start in the done cycle chains the next sweep with no idle state
    issue(2, 5, 2);
    wait_done(5);
    issue(6, 1, 3);
    wait_done(6);

    // reset mid-sweep
    plot_cnt = 0;
    issue(4, 4, 1);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("t6_plot", 32'(plot), 32'd0);
    check("t6_x", 32'(x), 32'd0);
    check("t6_y", 32'(y), 32'd0);
    check("t6_colour", 32'(colour), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_plots_before_reset", 32'(plot_cnt), 32'd100);
    reset = 1'b0;
    repeat (220) @(negedge clk);
    check("t6_no_done", 32'(done_cnt), 32'd6);
    issue(0, 7, 2);
    wait_done(7);

    // randomized redraws, gap 0 meaning back-to-back from the done cycle
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      wait_done(8 + i);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
